// File: rtl/alu_share_arbiter.sv
// Round-robin front end that lets two requesters share one external ALU:
// operand register in front of the ALU, held response register behind it.
module alu_share_arbiter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [13:0]       req_funct7,
  input  logic [5:0]        req_funct3,
  input  logic [2*XLEN-1:0] req_a,
  input  logic [2*XLEN-1:0] req_b,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [XLEN-1:0]   rsp_result,
  output logic [3:0]        rsp_flags,
  output logic [6:0]        alu_funct7,
  output logic [2:0]        alu_funct3,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [3:0]        alu_flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic              prio_r;
  logic              op_id_r;
  logic [6:0]        op_f7_r;
  logic [2:0]        op_f3_r;
  logic [XLEN-1:0]   op_a_r;
  logic [XLEN-1:0]   op_b_r;
  logic [XLEN-1:0]   rsp_result_r;
  logic [3:0]        rsp_flags_r;

  logic              rsp_hs_s;
  logic              window_s;
  logic              grant_s;
  logic              grant_id_s;

  // Response handshake, accept window and round-robin winner selection
  always_comb begin
    rsp_hs_s   = (state_r == RESP) && (op_id_r ? rsp_ready[1] : rsp_ready[0]);
    window_s   = rst_n && ((state_r == IDLE) || rsp_hs_s);
    grant_s    = window_s && (req_valid != 2'b00);
    grant_id_s = 1'b0;
    if (req_valid == 2'b11) begin
      grant_id_s = prio_r;
    end else begin
      grant_id_s = req_valid[1];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_next_s = EXEC;
        end else begin
          state_next_s = IDLE;
        end
      end
      EXEC: state_next_s = RESP;
      RESP: begin
        if (rsp_hs_s) begin
          state_next_s = grant_s ? EXEC : IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from state, owner and current grant
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    if (grant_s) begin
      req_ready = grant_id_s ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
    if (rst_n && (state_r == RESP)) begin
      rsp_valid = op_id_r ? 2'b10 : 2'b01;
    end else begin
      rsp_valid = 2'b00;
    end
  end

  // Operand latch on accept, priority rotation and response capture after EXEC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_r       <= 1'b0;
      op_id_r      <= 1'b0;
      op_f7_r      <= 7'd0;
      op_f3_r      <= 3'd0;
      op_a_r       <= {XLEN{1'b0}};
      op_b_r       <= {XLEN{1'b0}};
      rsp_result_r <= {XLEN{1'b0}};
      rsp_flags_r  <= 4'd0;
    end else begin
      if (grant_s) begin
        prio_r  <= ~grant_id_s;
        op_id_r <= grant_id_s;
        op_f7_r <= grant_id_s ? req_funct7[13:7] : req_funct7[6:0];
        op_f3_r <= grant_id_s ? req_funct3[5:3]  : req_funct3[2:0];
        op_a_r  <= grant_id_s ? req_a[2*XLEN-1:XLEN] : req_a[XLEN-1:0];
        op_b_r  <= grant_id_s ? req_b[2*XLEN-1:XLEN] : req_b[XLEN-1:0];
      end
      if (state_r == EXEC) begin
        rsp_result_r <= alu_result;
        rsp_flags_r  <= alu_flags;
      end
    end
  end

  assign alu_funct7 = op_f7_r;
  assign alu_funct3 = op_f3_r;
  assign alu_a      = op_a_r;
  assign alu_b      = op_b_r;
  assign rsp_result = rsp_result_r;
  assign rsp_flags  = rsp_flags_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached and a
// scoreboard queue checked by an independent response monitor.
module tb_alu_share_arbiter;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [13:0]     req_funct7;
  logic [5:0]      req_funct3;
  logic [63:0]     req_a;
  logic [63:0]     req_b;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [31:0]     rsp_result;
  logic [3:0]      rsp_flags;
  logic [6:0]      alu_funct7;
  logic [2:0]      alu_funct3;
  logic [31:0]     alu_a;
  logic [31:0]     alu_b;
  logic [31:0]     alu_result;
  logic [3:0]      alu_flags;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_share_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct7(req_funct7), .req_funct3(req_funct3),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_funct7(alu_funct7), .alu_funct3(alu_funct3),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flags(alu_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: flags always come from A - B ({V,C,N,Z}, C = no borrow)
  logic [32:0] diff_s;
  always_comb begin
    diff_s    = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
    alu_flags = {(alu_a[31] != alu_b[31]) && (diff_s[31] != alu_a[31]),
                 diff_s[32], diff_s[31], (diff_s[31:0] == 32'd0)};
    case (alu_funct3)
      3'b000:  alu_result = alu_funct7[5] ? diff_s[31:0] : (alu_a + alu_b);
      3'b010:  alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      3'b100:  alu_result = alu_a ^ alu_b;
      3'b110:  alu_result = alu_a | alu_b;
      3'b111:  alu_result = alu_a & alu_b;
      default: alu_result = 32'd0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic id, input logic [31:0] res, input logic [3:0] flg);
    exp_t e;
    e.id  = id;
    e.res = res;
    e.flg = flg;
    exp_q.push_back(e);
  endtask

  // Monitor: every completed response handshake pops and checks one entry
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ((rsp_valid & rsp_ready) != 2'b00)) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid=%b result=0x%0h, expected none", rsp_valid, rsp_result);
      end else begin
        e = exp_q.pop_front();
        check("rsp_owner", {62'd0, rsp_valid}, {62'd0, (e.id ? 2'b10 : 2'b01)});
        check("rsp_result", {32'd0, rsp_result}, {32'd0, e.res});
        check("rsp_flags", {60'd0, rsp_flags}, {60'd0, e.flg});
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 2'b00;
    req_funct7 = 14'd0;
    req_funct3 = 6'd0;
    req_a      = 64'd0;
    req_b      = 64'd0;
    rsp_ready  = 2'b00;
    tick();
    tick();
    check("reset_req_ready", {62'd0, req_ready}, 64'd0);
    check("reset_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    check("reset_alu_a", {32'd0, alu_a}, 64'd0);
    check("reset_rsp_result", {32'd0, rsp_result}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Single request: req0 ADD 5+3
    rsp_ready  = 2'b11;
    req_valid  = 2'b01;
    req_funct7 = {7'h00, 7'h00};
    req_funct3 = {3'b000, 3'b000};
    req_a      = {32'd0, 32'd5};
    req_b      = {32'd0, 32'd3};
    #1;
    check("single_req_ready", {62'd0, req_ready}, 64'd1);
    push(1'b0, 32'd8, 4'b0100);
    tick();
    req_valid = 2'b00;
    check("single_exec_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    tick();
    check("single_latency_rsp_valid", {62'd0, rsp_valid}, 64'd1);
    tick();

    // Overflow: req1 SUB 0x80000000 - 1
    req_valid  = 2'b10;
    req_funct7 = {7'h20, 7'h00};
    req_funct3 = {3'b000, 3'b000};
    req_a      = {32'h8000_0000, 32'd0};
    req_b      = {32'd1, 32'd0};
    #1;
    check("ovf_req_ready", {62'd0, req_ready}, 64'd2);
    push(1'b1, 32'h7FFF_FFFF, 4'b1100);
    tick();
    req_valid = 2'b00;
    tick();
    check("ovf_rsp_valid", {62'd0, rsp_valid}, 64'd2);
    tick();

    // Simultaneous: req0 OR 1|2, req1 XOR 7^1, grants alternate every 2 cycles
    req_valid  = 2'b11;
    req_funct7 = {7'h00, 7'h00};
    req_funct3 = {3'b100, 3'b110};
    req_a      = {32'd7, 32'd1};
    req_b      = {32'd1, 32'd2};
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_grant", {62'd0, req_ready}, ((i % 2) == 0) ? 64'd1 : 64'd2);
      if ((i % 2) == 0) push(1'b0, 32'd3, 4'b0010);
      else              push(1'b1, 32'd6, 4'b0100);
      tick();
      if (i == 3) req_valid = 2'b00;
      check("rr_exec_no_ready", {62'd0, req_ready}, 64'd0);
      tick();
    end
    tick();

    // Back-pressure: req0 SLT -1 < 0 held while req1 waits
    rsp_ready  = 2'b00;
    req_valid  = 2'b01;
    req_funct7 = {7'h00, 7'h20};
    req_funct3 = {3'b000, 3'b010};
    req_a      = {32'd10, 32'hFFFF_FFFF};
    req_b      = {32'd20, 32'd0};
    #1;
    check("bp_req_ready", {62'd0, req_ready}, 64'd1);
    push(1'b0, 32'd1, 4'b0110);
    tick();
    req_valid = 2'b10;
    tick();
    rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold_rsp_valid", {62'd0, rsp_valid}, 64'd1);
      check("bp_hold_result", {32'd0, rsp_result}, 64'd1);
      check("bp_hold_req_ready", {62'd0, req_ready}, 64'd0);
      tick();
    end
    rsp_ready = 2'b01;
    #1;
    check("bp_release_accept", {62'd0, req_ready}, 64'd2);
    push(1'b1, 32'd30, 4'b0010);
    tick();
    req_valid = 2'b00;
    tick();
    check("bp_req1_rsp_valid", {62'd0, rsp_valid}, 64'd2);
    rsp_ready = 2'b11;
    tick();

    // Reset while EXEC: the request is lost, priority returns to req0
    req_valid  = 2'b01;
    req_funct7 = {7'h00, 7'h00};
    req_funct3 = {3'b000, 3'b000};
    req_a      = {32'd2, 32'd100};
    req_b      = {32'd2, 32'd1};
    #1;
    check("rst_pre_req_ready", {62'd0, req_ready}, 64'd1);
    tick();
    rst_n = 1'b0;
    tick();
    check("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    check("rst_req_ready", {62'd0, req_ready}, 64'd0);
    check("rst_alu_ops", {alu_a, alu_b}, 64'd0);
    check("rst_alu_funct", {54'd0, alu_funct7, alu_funct3}, 64'd0);
    rst_n     = 1'b1;
    req_valid = 2'b00;
    tick();
    check("rst_idle_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    tick();
    check("rst_idle_rsp_valid2", {62'd0, rsp_valid}, 64'd0);
    req_valid  = 2'b11;
    req_funct3 = {3'b000, 3'b111};
    req_a      = {32'd2, 32'h0000_00F0};
    req_b      = {32'd2, 32'h0000_003C};
    #1;
    check("post_rst_grant0", {62'd0, req_ready}, 64'd1);
    push(1'b0, 32'h30, 4'b0100);
    tick();
    tick();
    check("post_rst_grant1", {62'd0, req_ready}, 64'd2);
    push(1'b1, 32'd4, 4'b0101);
    tick();
    req_valid = 2'b00;
    tick();
    tick();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
